hack_serial_tx: RTL and testbench
=================================

// Module: hack_serial_tx
// PURPOSE
// - Memory-mapped byte-serial transmitter: the Hack CPU writes words, the block emits 8N1 UART frames on tx.
// - Output-side counterpart of the keyboard/serial receive path; sits on the Hack data-memory bus beside
//   the Screen and Keyboard maps, decoded by the Memory block.
// - Small FIFO decouples CPU writes from the bit rate; status word lets software poll before writing.
// PARAMETERS
// - CLKS_PER_BIT  868  clock cycles per serial bit (115200 baud at 100 MHz); legal range >= 2
// - FIFO_DEPTH    4    byte entries; power of two, 2..16
// PORTS
// - clk      in   1   single clock; all state updates on rising edge
// - reset    in   1   synchronous, active-high; sampled on clk rising edge
// - in       in   16  write data from CPU (Hack M-bus)
// - load     in   1   write strobe, one word per cycle while high
// - address  in   1   0 = DATA register, 1 = STATUS register
// - out      out  16  read data, combinational from address and current state
// - tx       out  1   serial line, registered, idle high
// BEHAVIOUR
// - Reset: tx=1, FSM=IDLE, FIFO emptied, overflow=0; out reads STATUS 16'h0000 / DATA 16'h0000.
//   Reset mid-frame aborts the frame: tx=1 from the reset edge; queued bytes discarded.
// - Write DATA (load=1, address=0): in[7:0] pushed; in[15:8] ignored. If FIFO full (and no pop that
//   edge) byte dropped and overflow set. Push+pop on same edge while full: push accepted, count unchanged.
// - Write STATUS (load=1, address=1): in[2]=1 clears overflow; other bits ignored; nothing pushed.
// - Read: address=1 -> out = {13'b0, overflow, full, busy}; address=0 -> out = {8'b0, last pushed byte}.
// - busy = (FSM != IDLE) | FIFO not empty. full = count == FIFO_DEPTH.
// - FSM states IDLE, START, DATA, STOP; 16-bit-wide baud counter, 3-bit bit index.
//   - IDLE: tx=1; if FIFO not empty, pop head into shift reg, tx<=0, go START.
//   - START: hold tx=0 CLKS_PER_BIT cycles, then tx<=bit0, go DATA.
//   - DATA: each bit held CLKS_PER_BIT cycles, LSB first; after bit7 tx<=1, go STOP.
//   - STOP: hold tx=1 CLKS_PER_BIT cycles; then if FIFO not empty pop and enter START directly
//     (no idle cycle between frames), else IDLE.
// - Latency: write captured on edge E; with FSM IDLE and FIFO previously empty, tx falls on edge E+1.
// - Frame length exactly 10*CLKS_PER_BIT cycles; tx never glitches (single flop output).
// - Overflow is sticky until cleared by STATUS write or reset; clear and new overflow on the
//   same edge -> overflow stays 1.
// STRUCTURE
// - Shared include hack_io_defs.vh: ADDR_DATA/ADDR_STATUS, status bit indices (BUSY=0, FULL=1,
//   OVERFLOW=2), FSM state encodings (IDLE=0, START=1, DATA=2, STOP=3).
// - One sub-module: byte_fifo (params WIDTH=8, DEPTH; ports clk, reset, push, pop, din, dout,
//   full, empty, count); show-ahead dout, pointer wrap modulo DEPTH.
// - Top holds address decode, overflow flag, baud counter, bit index, shift reg, FSM, tx flop.
// TESTING (CLKS_PER_BIT=4, FIFO_DEPTH=4 unless stated)
// - Single byte: write DATA 16'h00A5 -> tx low 1 edge later, bits 1,0,1,0,0,1,0,1 each 4 cycles,
//   stop high 4 cycles; busy=1 throughout, 0 the cycle after return to IDLE; 40-cycle frame.
// - Back-to-back: write 8'h55, 8'hAA consecutive cycles -> two frames, second start bit begins
//   immediately after first stop bit; 80 cycles total, no idle gap.
// - Overflow: 6 writes in 6 consecutive cycles (0x01..0x06) -> first byte popped at edge 2, 5th
//   write accepted, 6th dropped; STATUS reads 16'h0007; frames 01..05 emitted; write STATUS
//   16'h0004 -> overflow cleared.
// - Full + pop same edge: fill FIFO while FSM finishes STOP, push on pop edge -> accepted, overflow=0.
// - Reset mid-frame: assert reset during DATA bit 3 -> tx=1 next edge, STATUS 16'h0000,
//   no further frames after reset released.
// - Upper bits ignored: write 16'hFF3C -> frame carries 8'h3C; DATA read returns 16'h003C.

Source files
------------

// File: rtl/hack_serial_tx_pkg.sv
// Shared definitions for the Hack memory-mapped serial transmitter:
// register addresses, status bit positions and transmit FSM states.
package hack_serial_tx_pkg;

  localparam logic ADDR_DATA   = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_FULL     = 1;
  localparam int STAT_OVERFLOW = 2;

  localparam int BAUD_W    = 16;
  localparam int BIT_IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } txState_t;

  function automatic logic [15:0] packStatus(input logic overflow, input logic full,
                                             input logic busy);
    return {13'b0, overflow, full, busy};
  endfunction

endpackage

// File: rtl/hack_serial_tx_if.sv
// Hack data-memory bus slice seen by the serial transmitter: CPU write data,
// write strobe, one-bit register select and combinational read data.
interface hack_serial_tx_if;
  logic [15:0] in;
  logic        load;
  logic        address;
  logic [15:0] out;

  modport master (output in, output load, output address, input out);
  modport slave  (input in, input load, input address, output out);
endinterface

// File: rtl/hack_serial_tx_byte_fifo.sv
// Small show-ahead FIFO; dout always presents the head entry. A push while
// full is accepted only when a pop happens on the same edge.
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] memQ [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pushOk;
  logic             popOk;

  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign count  = count_q;
  assign dout   = memQ[rdPtr_q];
  assign popOk  = pop && !empty;
  assign pushOk = push && (!full || popOk);

  // DEPTH is a power of two, so pointers wrap naturally at PTR_W bits.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (pushOk) wrPtr_d = wrPtr_q + PTR_W'(1);
    if (popOk)  rdPtr_d = rdPtr_q + PTR_W'(1);
    if (pushOk && !popOk) count_d = count_q + CNT_W'(1);
    if (popOk && !pushOk) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pushOk) memQ[wrPtr_q] <= din;
  end

endmodule

// File: rtl/hack_serial_tx.sv
// Memory-mapped 8N1 UART transmitter for the Hack data bus: CPU writes bytes
// into a FIFO, the FSM shifts them out LSB first on a registered tx line.
module hack_serial_tx
  import hack_serial_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  hack_serial_tx_if.slave   bus,
  output logic              tx
);

  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  txState_t             state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_IDX_W-1:0] bitIdx_q, bitIdx_d;
  logic [7:0]           shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 overflow_q, overflow_d;
  logic [7:0]           lastByte_q, lastByte_d;

  logic             dataWrite;
  logic             statusWrite;
  logic             fifoPop;
  logic             fifoFull;
  logic             fifoEmpty;
  logic [7:0]       fifoDout;
  logic [CNT_W-1:0] fifoCount;
  logic             baudDone;
  logic             busy;
  logic             unusedBits;

  assign dataWrite   = bus.load && (bus.address == ADDR_DATA);
  assign statusWrite = bus.load && (bus.address == ADDR_STATUS);
  assign baudDone    = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign busy        = (state_q != ST_IDLE) || !fifoEmpty;
  assign tx          = tx_q;
  assign unusedBits  = ^{bus.in[15:8], fifoCount};

  byte_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (dataWrite),
    .pop   (fifoPop),
    .din   (bus.in[7:0]),
    .dout  (fifoDout),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  always_comb begin
    bus.out = {8'b0, lastByte_q};
    if (bus.address == ADDR_STATUS) bus.out = packStatus(overflow_q, fifoFull, busy);
  end

  // A fresh overflow on the same edge as a clear must win, so set is applied last.
  always_comb begin
    overflow_d = overflow_q;
    lastByte_d = lastByte_q;
    if (statusWrite && bus.in[STAT_OVERFLOW]) overflow_d = 1'b0;
    if (dataWrite && fifoFull && !fifoPop)    overflow_d = 1'b1;
    if (dataWrite && (!fifoFull || fifoPop))  lastByte_d = bus.in[7:0];
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    fifoPop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifoEmpty) begin
          fifoPop = 1'b1;
          shift_d = fifoDout;
          tx_d    = 1'b0;
          baud_d  = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baudDone) begin
          baud_d   = '0;
          bitIdx_d = '0;
          tx_d     = shift_q[0];
          state_d  = ST_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baudDone) begin
          baud_d = '0;
          if (bitIdx_q == BIT_IDX_W'(7)) begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end else begin
            bitIdx_d = bitIdx_q + BIT_IDX_W'(1);
            shift_d  = {1'b0, shift_q[7:1]};
            tx_d     = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (baudDone) begin
          baud_d = '0;
          // Chain straight into the next start bit so frames have no idle gap.
          if (!fifoEmpty) begin
            fifoPop = 1'b1;
            shift_d = fifoDout;
            tx_d    = 1'b0;
            state_d = ST_START;
          end else begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
      lastByte_q <= '0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
      lastByte_q <= lastByte_d;
    end
  end

endmodule

// File: tb/tb_hack_serial_tx.sv
// Self-checking bench for hack_serial_tx: a line monitor decodes 8N1 frames from tx,
// and expected bytes/start cycles come from the write sequence and frame-timing rules.
module tb_hack_serial_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic reset;
  logic tx;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic [7:0] rxQ[$];
  int         rxT[$];
  bit         rxOk[$];
  logic [7:0] expQ[$];
  int         expT[$];

  hack_serial_tx_if busIf ();

  hack_serial_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (busIf.slave),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: on a falling edge, samples 40 negedges and records byte, start cycle, framing.
  initial begin : lineMonitor
    logic       prevTx;
    logic [7:0] b;
    logic       s;
    bit         ok;
    int         t;
    prevTx = 1'b1;
    forever begin
      @(negedge clk);
      if (prevTx === 1'b1 && tx === 1'b0) begin
        t  = cyc;
        ok = 1'b1;
        b  = 8'h00;
        for (int k = 1; k < CPB; k++) begin
          @(negedge clk);
          if (tx !== 1'b0) ok = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          s    = tx;
          b[i] = s;
          if (s !== 1'b0 && s !== 1'b1) ok = 1'b0;
          for (int k = 1; k < CPB; k++) begin
            @(negedge clk);
            if (tx !== s) ok = 1'b0;
          end
        end
        for (int k = 0; k < CPB; k++) begin
          @(negedge clk);
          if (tx !== 1'b1) ok = 1'b0;
        end
        rxQ.push_back(b);
        rxT.push_back(t);
        rxOk.push_back(ok);
      end
      prevTx = tx;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one bus cycle; returns the clock edge number on which it was captured.
  task automatic applyStimulus(input logic ld, input logic addr, input logic [15:0] data,
                               output int edgeNo);
    busIf.load    = ld;
    busIf.address = addr;
    busIf.in      = data;
    @(negedge clk);
    edgeNo     = cyc;
    busIf.load = 1'b0;
  endtask

  task automatic checkBus(input string tag, input logic addr, input logic [15:0] expected);
    busIf.load    = 1'b0;
    busIf.address = addr;
    #1;
    checkOutput(tag, {16'h0, busIf.out}, {16'h0, expected});
  endtask

  task automatic idleTo(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic expectFrames(input int firstEdge, input logic [7:0] bytes[$]);
    for (int i = 0; i < bytes.size(); i++) begin
      expQ.push_back(bytes[i]);
      expT.push_back(firstEdge + 1 + FRAME * i);
    end
  endtask

  task automatic drainAndCompare(input string tag);
    int w;
    w = 0;
    while (w < 3000 && rxQ.size() < expQ.size()) begin
      @(negedge clk);
      w++;
    end
    checkOutput({tag, "_count"}, rxQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < rxQ.size(); i++) begin
      checkOutput($sformatf("%s_byte%0d", tag, i), {24'h0, rxQ[i]}, {24'h0, expQ[i]});
      checkOutput($sformatf("%s_start%0d", tag, i), rxT[i], expT[i]);
      checkOutput($sformatf("%s_framing%0d", tag, i), {31'h0, rxOk[i]}, 32'h1);
    end
    rxQ.delete();
    rxT.delete();
    rxOk.delete();
    expQ.delete();
    expT.delete();
    idleTo(cyc + 3);
  endtask

  initial begin
    int         e;
    int         e0;
    int         n;
    logic [15:0] w;
    logic [7:0] bytes[$];

    reset         = 1'b1;
    busIf.load    = 1'b0;
    busIf.address = 1'b0;
    busIf.in      = 16'h0;
    repeat (3) @(negedge clk);
    checkOutput("reset_tx", {31'h0, tx}, 32'h1);
    checkBus("reset_status", 1'b1, 16'h0000);
    checkBus("reset_data", 1'b0, 16'h0000);
    reset = 1'b0;
    idleTo(cyc + 2);

    // Single byte: timing, busy window, data readback.
    applyStimulus(1'b1, 1'b0, 16'h00A5, e);
    checkBus("single_busy_start", 1'b1, 16'h0001);
    checkBus("single_data", 1'b0, 16'h00A5);
    idleTo(e + FRAME);
    checkBus("single_busy_end", 1'b1, 16'h0001);
    idleTo(e + FRAME + 1);
    checkBus("single_idle_after", 1'b1, 16'h0000);
    bytes = '{8'hA5};
    expectFrames(e, bytes);
    drainAndCompare("single");

    // Back-to-back frames with no idle gap.
    applyStimulus(1'b1, 1'b0, 16'h0055, e);
    applyStimulus(1'b1, 1'b0, 16'h00AA, n);
    bytes = '{8'h55, 8'hAA};
    expectFrames(e, bytes);
    drainAndCompare("b2b");

    // Overflow: six consecutive writes, the sixth is dropped.
    applyStimulus(1'b1, 1'b0, 16'h0001, e);
    for (int i = 2; i <= 6; i++) applyStimulus(1'b1, 1'b0, 16'(i), n);
    checkBus("ovf_status", 1'b1, 16'h0007);
    bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    expectFrames(e, bytes);
    drainAndCompare("ovf");
    checkBus("ovf_sticky", 1'b1, 16'h0004);
    applyStimulus(1'b1, 1'b1, 16'hFFFB, n);
    checkBus("ovf_noclear", 1'b1, 16'h0004);
    applyStimulus(1'b1, 1'b1, 16'h0004, n);
    checkBus("ovf_cleared", 1'b1, 16'h0000);
    checkOutput("ovf_no_extra", rxQ.size(), 0);

    // Full FIFO plus pop on the same edge: the push must be accepted.
    applyStimulus(1'b1, 1'b0, 16'h0011, e0);
    idleTo(e0 + FRAME - 4);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 16'(8'h21 + i), n);
    checkOutput("fullpop_edge", n, e0 + FRAME + 1);
    checkBus("fullpop_status", 1'b1, 16'h0003);
    bytes = '{8'h11, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
    expectFrames(e0, bytes);
    drainAndCompare("fullpop");
    checkBus("fullpop_noovf", 1'b1, 16'h0000);

    // Upper bits of the write word are ignored.
    applyStimulus(1'b1, 1'b0, 16'hFF3C, e);
    checkBus("upper_data", 1'b0, 16'h003C);
    bytes = '{8'h3C};
    expectFrames(e, bytes);
    drainAndCompare("upper");

    // Randomized bursts of 1..5 writes; all fit, frames chain every 40 cycles.
    for (int b = 0; b < 6; b++) begin
      n = $urandom_range(1, 5);
      bytes.delete();
      for (int i = 0; i < n; i++) begin
        w = 16'($urandom);
        bytes.push_back(w[7:0]);
        applyStimulus(1'b1, 1'b0, w, e0);
        if (i == 0) e = e0;
      end
      checkBus($sformatf("rand%0d_lastdata", b), 1'b0, {8'h00, bytes[n-1]});
      expectFrames(e, bytes);
      drainAndCompare($sformatf("rand%0d", b));
    end

    // Reset during data bit 3 aborts the frame and discards the queued byte.
    applyStimulus(1'b1, 1'b0, 16'h005A, e);
    applyStimulus(1'b1, 1'b0, 16'h00C3, n);
    idleTo(e + 18);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_tx", {31'h0, tx}, 32'h1);
    checkBus("rst_mid_status", 1'b1, 16'h0000);
    checkBus("rst_mid_data", 1'b0, 16'h0000);
    reset = 1'b0;
    idleTo(cyc + 60);
    rxQ.delete();
    rxT.delete();
    rxOk.delete();
    idleTo(cyc + 100);
    checkOutput("rst_no_frames", rxQ.size(), 0);
    checkOutput("rst_tx_idle", {31'h0, tx}, 32'h1);
    checkBus("rst_status_after", 1'b1, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
